// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: base opcodes, the canonical NOP encoding and the
// instruction-fetch state encoding.
package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // ADDI x0,x0,0
    localparam logic [31:0] NOP_ENCODING = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {instr, pc} holding register that catches a fetch response
// arriving while decode is stalled.
module fetch_skid_buffer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        full
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
        end
    end

    // Payload is qualified by full, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            instr <= instr_in;
            pc    <= pc_in;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: PC, instruction-memory requests, skid buffer and IF/ID register.
// Optional macro FETCH_MISALIGN_TRAP_EN adds the FETCH_MISALIGNED flag output.
module instruction_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = NOP_ENCODING
) (
    input  logic        CLK,
    input  logic        RESET_N,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDR,
    input  logic [31:0] IMEM_INSTR,
    input  logic        IMEM_BUSYWAIT,
    input  logic        STALL,
    input  logic        PC_SELECT,
    input  logic [31:0] BRANCH_TARGET,
    output logic [31:0] INSTR,
    output logic [31:0] PC_OUT,
    output logic [31:0] PC_PLUS4,
    output logic        VALID,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        FETCH_MISALIGNED,
`endif
    output logic [6:0]  OPCODE,
    output logic [2:0]  FUNC3,
    output logic [6:0]  FUNC7,
    output logic [4:0]  RD,
    output logic [4:0]  RS1,
    output logic [4:0]  RS2
);

    fetch_state_e state_q, state_d;

    logic [31:0] pc_p0, pc_d;
    logic [31:0] instr_p1, instr_d;
    logic [31:0] pc_p1, pc_p1_d;
    logic        vld_p1, vld_d;

    logic        skid_load, skid_clear, skid_full;
    logic [31:0] skid_instr, skid_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misaligned_q, misaligned_d;
`endif

    fetch_skid_buffer u_skid (
        .clk      (CLK),
        .rst_n    (RESET_N),
        .load     (skid_load),
        .clear    (skid_clear),
        .instr_in (IMEM_INSTR),
        .pc_in    (pc_p0),
        .instr    (skid_instr),
        .pc       (skid_pc),
        .full     (skid_full)
    );

    // Fetch stage -> IF/ID boundary
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= FETCH_IDLE;
            pc_p0    <= RESET_VECTOR;
            instr_p1 <= NOP_INSTR;
            pc_p1    <= RESET_VECTOR;
            vld_p1   <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misaligned_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_p0    <= pc_d;
            instr_p1 <= instr_d;
            pc_p1    <= pc_p1_d;
            vld_p1   <= vld_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            misaligned_q <= misaligned_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_p0;
        instr_d    = instr_p1;
        pc_p1_d    = pc_p1;
        vld_d      = vld_p1;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        IMEM_READ  = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        misaligned_d = misaligned_q;
`endif

        case (state_q)
            FETCH_IDLE: begin
                state_d = FETCH_REQ;
            end
            FETCH_REQ: begin
`ifdef FETCH_MISALIGN_TRAP_EN
                IMEM_READ = !misaligned_q;
`else
                IMEM_READ = 1'b1;
`endif
                if (IMEM_READ && !IMEM_BUSYWAIT) begin
                    pc_d = pc_p0 + 32'd4;
                    if (STALL) begin
                        skid_load = 1'b1;
                        state_d   = FETCH_HOLD;
                    end else begin
                        instr_d = IMEM_INSTR;
                        pc_p1_d = pc_p0;
                        vld_d   = 1'b1;
                    end
                end else if (!STALL) begin
                    instr_d = NOP_INSTR;
                    vld_d   = 1'b0;
                end
            end
            FETCH_HOLD: begin
                if (!STALL) begin
                    instr_d    = skid_instr;
                    pc_p1_d    = skid_pc;
                    vld_d      = skid_full;
                    skid_clear = 1'b1;
                    state_d    = FETCH_REQ;
                end
            end
            default: begin
                state_d = FETCH_IDLE;
            end
        endcase

        // A redirect overrides everything above, including a same-cycle response.
        if (PC_SELECT) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            pc_d         = BRANCH_TARGET;
            misaligned_d = (BRANCH_TARGET[1:0] != 2'b00);
`else
            pc_d         = BRANCH_TARGET & ~32'h0000_0003;
`endif
            instr_d    = NOP_INSTR;
            vld_d      = 1'b0;
            skid_load  = 1'b0;
            skid_clear = 1'b1;
            state_d    = FETCH_REQ;
        end
    end

    assign IMEM_ADDR = pc_p0;
    assign INSTR     = instr_p1;
    assign PC_OUT    = pc_p1;
    assign PC_PLUS4  = pc_p1 + 32'd4;
    assign VALID     = vld_p1;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign FETCH_MISALIGNED = misaligned_q;
`endif

    assign OPCODE = instr_p1[6:0];
    assign RD     = instr_p1[11:7];
    assign FUNC3  = instr_p1[14:12];
    assign RS1    = instr_p1[19:15];
    assign RS2    = instr_p1[24:20];
    assign FUNC7  = instr_p1[31:25];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: sequential fetch, wait states,
// decode stall, redirect, PC wrap, misaligned target and reset mid-wait.
module tb_instruction_fetch_unit;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        IMEM_READ;
    logic [31:0] IMEM_ADDR;
    logic [31:0] IMEM_INSTR;
    logic        IMEM_BUSYWAIT;
    logic        STALL;
    logic        PC_SELECT;
    logic [31:0] BRANCH_TARGET;
    logic [31:0] INSTR;
    logic [31:0] PC_OUT;
    logic [31:0] PC_PLUS4;
    logic        VALID;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        FETCH_MISALIGNED;
`endif
    logic [6:0]  OPCODE;
    logic [2:0]  FUNC3;
    logic [6:0]  FUNC7;
    logic [4:0]  RD;
    logic [4:0]  RS1;
    logic [4:0]  RS2;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    instruction_fetch_unit dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .IMEM_READ     (IMEM_READ),
        .IMEM_ADDR     (IMEM_ADDR),
        .IMEM_INSTR    (IMEM_INSTR),
        .IMEM_BUSYWAIT (IMEM_BUSYWAIT),
        .STALL         (STALL),
        .PC_SELECT     (PC_SELECT),
        .BRANCH_TARGET (BRANCH_TARGET),
        .INSTR         (INSTR),
        .PC_OUT        (PC_OUT),
        .PC_PLUS4      (PC_PLUS4),
        .VALID         (VALID),
`ifdef FETCH_MISALIGN_TRAP_EN
        .FETCH_MISALIGNED (FETCH_MISALIGNED),
`endif
        .OPCODE        (OPCODE),
        .FUNC3         (FUNC3),
        .FUNC7         (FUNC7),
        .RD            (RD),
        .RS1           (RS1),
        .RS2           (RS2)
    );

    always #5 CLK = ~CLK;

    // Memory image: word 0 holds ADDI x1,x0,5, every other word is an
    // OP-IMM whose upper bits echo its own address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return {a[24:0], 7'b0010011};
    endfunction

    assign IMEM_INSTR = mem_word(IMEM_ADDR);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET_N       = 1'b0;
        IMEM_BUSYWAIT = 1'b0;
        STALL         = 1'b0;
        PC_SELECT     = 1'b0;
        BRANCH_TARGET = 32'h0;
        tick();
        tick();
        check("rst_read",   {31'b0, IMEM_READ}, 32'd0);
        check("rst_instr",  INSTR, NOP);
        check("rst_valid",  {31'b0, VALID}, 32'd0);
        check("rst_pc_out", PC_OUT, 32'h0);
        check("rst_pc_p4",  PC_PLUS4, 32'h4);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("rst_misal",  {31'b0, FETCH_MISALIGNED}, 32'd0);
`endif
        RESET_N = 1'b1;

        // IDLE -> REQ, then back-to-back fetches
        tick();
        check("req_read", {31'b0, IMEM_READ}, 32'd1);
        check("req_addr0", IMEM_ADDR, 32'h0);
        check("idle_valid", {31'b0, VALID}, 32'd0);
        tick();
        check("f0_addr",   IMEM_ADDR, 32'h4);
        check("f0_instr",  INSTR, 32'h0050_0093);
        check("f0_opcode", {25'b0, OPCODE}, 32'h13);
        check("f0_rd",     {27'b0, RD}, 32'd1);
        check("f0_valid",  {31'b0, VALID}, 32'd1);
        check("f0_pc",     PC_OUT, 32'h0);
        check("f0_pc4",    PC_PLUS4, 32'h4);
        tick();
        check("f1_addr",   IMEM_ADDR, 32'h8);
        check("f1_pc",     PC_OUT, 32'h4);
        check("f1_instr",  INSTR, 32'h0000_0213);

        // three wait-state cycles at PC=8
        IMEM_BUSYWAIT = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bw_addr",  IMEM_ADDR, 32'h8);
            check("bw_valid", {31'b0, VALID}, 32'd0);
            check("bw_instr", INSTR, NOP);
        end
        IMEM_BUSYWAIT = 1'b0;
        tick();
        check("bw_done_pc",    PC_OUT, 32'h8);
        check("bw_done_valid", {31'b0, VALID}, 32'd1);
        check("bw_done_instr", INSTR, 32'h0000_0413);
        check("bw_done_addr",  IMEM_ADDR, 32'hC);

        // response for PC=12 arrives under a two-cycle stall
        STALL = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("st_read",  {31'b0, IMEM_READ}, 32'd0);
            check("st_pc",    PC_OUT, 32'h8);
            check("st_instr", INSTR, 32'h0000_0413);
            check("st_valid", {31'b0, VALID}, 32'd1);
        end
        STALL = 1'b0;
        tick();
        check("st_rel_pc",    PC_OUT, 32'hC);
        check("st_rel_instr", INSTR, 32'h0000_0613);
        check("st_rel_valid", {31'b0, VALID}, 32'd1);
        check("st_rel_addr",  IMEM_ADDR, 32'h10);
        check("st_rel_read",  {31'b0, IMEM_READ}, 32'd1);

        // redirect beats a same-cycle stall and response
        STALL         = 1'b1;
        PC_SELECT     = 1'b1;
        BRANCH_TARGET = 32'h100;
        tick();
        check("rd_addr",  IMEM_ADDR, 32'h100);
        check("rd_valid", {31'b0, VALID}, 32'd0);
        check("rd_instr", INSTR, NOP);
        check("rd_read",  {31'b0, IMEM_READ}, 32'd1);
        STALL     = 1'b0;
        PC_SELECT = 1'b0;
        tick();
        check("rd_pc",    PC_OUT, 32'h100);
        check("rd_valid2", {31'b0, VALID}, 32'd1);
        check("rd_instr2", INSTR, 32'h0000_8013);

        // PC wraps modulo 2^32
        PC_SELECT     = 1'b1;
        BRANCH_TARGET = 32'hFFFF_FFFC;
        tick();
        check("wr_addr", IMEM_ADDR, 32'hFFFF_FFFC);
        PC_SELECT = 1'b0;
        tick();
        check("wr_pc",    PC_OUT, 32'hFFFF_FFFC);
        check("wr_pc4",   PC_PLUS4, 32'h0);
        check("wr_addr0", IMEM_ADDR, 32'h0);
        tick();
        check("wr_next_pc", PC_OUT, 32'h0);

        // misaligned redirect target
        PC_SELECT     = 1'b1;
        BRANCH_TARGET = 32'h102;
        tick();
        PC_SELECT = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        check("ma_flag",  {31'b0, FETCH_MISALIGNED}, 32'd1);
        check("ma_read",  {31'b0, IMEM_READ}, 32'd0);
        check("ma_valid", {31'b0, VALID}, 32'd0);
        tick();
        check("ma_sticky", {31'b0, FETCH_MISALIGNED}, 32'd1);
        check("ma_read2",  {31'b0, IMEM_READ}, 32'd0);
        check("ma_instr",  INSTR, NOP);
`else
        check("ma_addr",  IMEM_ADDR, 32'h100);
        check("ma_read",  {31'b0, IMEM_READ}, 32'd1);
        tick();
        check("ma_pc",    PC_OUT, 32'h100);
`endif
        PC_SELECT     = 1'b1;
        BRANCH_TARGET = 32'h200;
        tick();
        PC_SELECT = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        check("ma_clear", {31'b0, FETCH_MISALIGNED}, 32'd0);
`endif
        check("ma_re_addr", IMEM_ADDR, 32'h200);
        check("ma_re_read", {31'b0, IMEM_READ}, 32'd1);
        tick();
        check("ma_re_pc",    PC_OUT, 32'h200);
        check("ma_re_valid", {31'b0, VALID}, 32'd1);

        // reset while a request is waiting; late response must be ignored
        IMEM_BUSYWAIT = 1'b1;
        tick();
        RESET_N = 1'b0;
        #2;
        check("mr_read",  {31'b0, IMEM_READ}, 32'd0);
        check("mr_addr",  IMEM_ADDR, 32'h0);
        check("mr_valid", {31'b0, VALID}, 32'd0);
        tick();
        RESET_N       = 1'b1;
        IMEM_BUSYWAIT = 1'b0;
        tick();
        check("mr_idle_valid", {31'b0, VALID}, 32'd0);
        check("mr_idle_instr", INSTR, NOP);
        check("mr_req_addr",   IMEM_ADDR, 32'h0);
        tick();
        check("mr_f_pc",    PC_OUT, 32'h0);
        check("mr_f_instr", INSTR, 32'h0050_0093);
        check("mr_f_valid", {31'b0, VALID}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
IF stage feeding the control_unit decode path. Owns the PC, issues instruction-memory reads, and holds the IF/ID pipeline register. Presents the instruction and its split fields (OPCODE, FUNC3, FUNC7, RD, RS1, RS2) with a VALID qualifier. Handles memory wait states, decode stalls and branch/jump redirects.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value after reset
NOP_INSTR, 32'h0000_0013, bubble encoding (ADDI x0,x0,0)

Ports:
CLK  in  1  clock, rising edge
RESET_N  in  1  asynchronous, active-low reset
IMEM_READ  out  1  instruction-memory read request
IMEM_ADDR  out  32  word-aligned fetch address (= PC)
IMEM_INSTR  in  32  read data, valid when IMEM_READ=1 and IMEM_BUSYWAIT=0
IMEM_BUSYWAIT  in  1  memory not ready this cycle
STALL  in  1  decode cannot accept; hold IF/ID
PC_SELECT  in  1  redirect request (branch taken / JAL / JALR)
BRANCH_TARGET  in  32  redirect address
INSTR  out  32  IF/ID instruction
PC_OUT  out  32  PC of INSTR
PC_PLUS4  out  32  PC_OUT+4 (JAL/JALR link)
VALID  out  1  INSTR is real (not a bubble)
OPCODE  out  7  INSTR[6:0]
FUNC3  out  3  INSTR[14:12]
FUNC7  out  7  INSTR[31:25]
RD  out  5  INSTR[11:7]
RS1  out  5  INSTR[19:15]
RS2  out  5  INSTR[24:20]

Behaviour:
- Reset (RESET_N=0, async): PC=RESET_VECTOR, state IDLE, IMEM_READ=0, INSTR=NOP_INSTR, PC_OUT=RESET_VECTOR, PC_PLUS4=RESET_VECTOR+4, VALID=0, skid buffer empty. Field outputs are pure slices of INSTR.
- States: IDLE, REQ, HOLD.
- IDLE: first edge after reset release goes to REQ. IMEM_READ=0.
- REQ: IMEM_READ=1, IMEM_ADDR=PC.
  - Response (BUSYWAIT=0) and STALL=0: IF/ID <= {IMEM_INSTR, PC}, VALID=1, PC<=PC+4. Stay in REQ. Back-to-back fetch gives 1 instruction/cycle.
  - Response and STALL=1: instruction and PC go to the skid buffer, PC<=PC+4, go to HOLD. IF/ID is unchanged.
  - BUSYWAIT=1 and STALL=0: IF/ID <= bubble (NOP_INSTR, VALID=0). PC is held.
  - BUSYWAIT=1 and STALL=1: IF/ID held, PC held.
- HOLD: IMEM_READ=0. While STALL=1, everything is held. When STALL=0: IF/ID <= skid, VALID=1, skid is emptied, go to REQ.
- Redirect (PC_SELECT=1) beats stall and response:
  - PC <= {BRANCH_TARGET[31:2],2'b00}.
  - IF/ID <= bubble.
  - Skid is emptied.
  - Any same-cycle IMEM response is discarded.
  - State goes to REQ.
  - Next-cycle IMEM_ADDR is the target.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 0.
- Latency: address issued in cycle N with no wait gives INSTR/VALID in cycle N+1.
- Reset mid-wait: the outstanding request is abandoned and the late response is ignored (state IDLE).

Optional Feature:
Macro FETCH_MISALIGN_TRAP_EN.
- Defined: adds output FETCH_MISALIGNED (1). A redirect with BRANCH_TARGET[1:0]!=0 sets it on the next edge.
  - PC is loaded unmasked, IMEM_READ is forced to 0, and IF/ID holds the bubble.
  - The flag is sticky until the next redirect or reset. Reset value is 0.
- Undefined: no port; low two bits are silently forced to 00.

Decomposition:
- Shared package riscv_pkg: RV32 opcode constants (OP 0110011, OP_IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111), NOP_INSTR value, fetch state encoding (IDLE/REQ/HOLD).
- One sub-module is natural: fetch_skid_buffer (1-entry {instr,pc} register with load/clear/full).

Test Plan:
- Reset release, memory returning ADDI x1,x0,5 (32'h0050_0093) with no wait -> IMEM_ADDR 0,4,8 on consecutive cycles; INSTR=32'h0050_0093, OPCODE=0010011, RD=1, VALID=1, PC_OUT=0, PC_PLUS4=4.
- BUSYWAIT=1 for 3 cycles at PC=8 -> IMEM_ADDR stays 8; VALID=0 and INSTR=NOP for 3 cycles; then PC_OUT=8, VALID=1.
- STALL=1 for 2 cycles while the response arrives at PC=12 -> IF/ID holds the old instruction; state HOLD, IMEM_READ=0; on release, PC_OUT=12, next IMEM_ADDR=16.
- PC_SELECT=1, BRANCH_TARGET=32'h100, same cycle as STALL=1 and a response -> next cycle IMEM_ADDR=32'h100, VALID=0; response discarded; following cycle PC_OUT=32'h100.
- PC preloaded to 32'hFFFF_FFFC via redirect -> next fetch address 0; PC_PLUS4 of that instruction = 0.
- With FETCH_MISALIGN_TRAP_EN, BRANCH_TARGET=32'h102 -> FETCH_MISALIGNED=1, IMEM_READ=0. Redirect to 32'h200 -> flag cleared, fetch resumes at 32'h200. Without the macro, same target -> IMEM_ADDR=32'h100.
